sseg_serial_driver: RTL and testbench
=====================================

// Module: sseg_serial_driver
// PURPOSE
//  Parametrised serial driver for daisy-chained 8-bit seven-segment shift registers.
//  Encodes NUM_DIGITS hex nibbles into segment bytes; per-digit decimal point, blanking and a raw-segment mode.
//  Shifts each frame out on ss_dout/ss_clk, then pulses ss_en to latch it.
//  Sits between the user data path and the board display pins; successor to the fixed 8-digit serial driver.
// PARAMETERS
//  NUM_DIGITS     8   digits in chain (1..16); frame = 8*NUM_DIGITS bits
//  CLK_DIV        4   clk cycles per ss_clk half-period (tick); >=1
//  SEG_ACTIVE_LOW 1   1: invert every segment byte after encoding (board default)
//  AUTO_REFRESH   1   1: retransmit held frame continuously; 0: send only on load
//  GAP_TICKS      16  idle ticks between auto-refresh frames (>=1)
// PORTS
//  clk        in   1            system clock, all logic on rising edge
//  rst_n      in   1            asynchronous active-low reset
//  data_in    in   4*NUM_DIGITS hex nibble per digit, digit 0 = [3:0]
//  dp_in      in   NUM_DIGITS   decimal point per digit, 1 = lit
//  blank_in   in   NUM_DIGITS   1 = digit fully dark (incl. dp)
//  raw_mode   in   1            1 = use raw_in bytes unchanged (polarity still applied)
//  raw_in     in   8*NUM_DIGITS raw segment bytes {dp,g,f,e,d,c,b,a}, digit 0 = [7:0]
//  load_valid in   1            request to capture inputs as next frame
//  load_ready out  1            1 in IDLE/GAP; load accepted when valid&&ready
//  busy       out  1            1 while shifting or latching
//  frame_done out  1            1-cycle pulse on the clk cycle ss_en falls
//  ss_dout    out  1            serial data, MSB of frame first
//  ss_clk     out  1            shift clock; receiver samples on rising edge
//  ss_en      out  1            latch strobe; receiver latches on rising edge
// BEHAVIOUR
//  Reset (async): all outputs 0 except load_ready=1; frame reg = all-dark encoding; FSM IDLE; tick counter 0.
//  Tick: counter 0..CLK_DIV-1; tick fires on wrap; counter held at 0 in IDLE.
//  Encode at accept: byte = raw_mode ? raw_in[d] : {dp_in[d], hex7(data_in[d])}; blank_in[d] forces 0x00; then ^0xFF if SEG_ACTIVE_LOW.
//   hex7 {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  Frame reg = {byte[N-1],...,byte[0]}; transmit MSB first, so after 8N shifts receiver holds digit 0 in its LSB byte.
//  FSM: IDLE -(valid&&ready, or AUTO_REFRESH after reset)-> SHIFT_LO -> SHIFT_HI -> (bits left ? SHIFT_LO : LATCH)
//       -> LATCH (2 ticks) -> GAP (AUTO_REFRESH: GAP_TICKS ticks, then SHIFT_LO) / IDLE (AUTO_REFRESH=0).
//   SHIFT_LO (1 tick): ss_clk=0, ss_dout = current bit (registered, stable entire low+high phase).
//   SHIFT_HI (1 tick): ss_clk=1; bit counter decrements at end of tick.
//   LATCH: ss_clk=0, ss_dout=0, ss_en=1 for 2 ticks; frame_done on falling clk cycle.
//  Exactly 8N ss_clk rising edges per ss_en pulse; ss_en never high while ss_clk high.
//  ss_en rises >=1 tick after the last ss_clk rise.
//  Frame time = (16N+2)*CLK_DIV clk cycles; first SHIFT_LO starts the cycle after accept.
//  Load in GAP: accepted, GAP aborted, new frame starts next cycle. load_valid while busy: ignored (ready=0), no queueing.
//  Input changes during a frame do not affect it (frame reg captured only on accept).
//  Reset mid-frame: outputs drop immediately; no ss_en, so the display keeps its last latched frame.
//  All outputs registered; no combinational path from inputs to pins.
// STRUCTURE
//  sseg_pkg: hex7 lookup function, segment-byte width constant, FSM state enum.
//  Sub-module sseg_encoder (combinational per-digit encode, generate over NUM_DIGITS); FSM/shifter in top.
// TESTING (NUM_DIGITS=8, CLK_DIV=1, AUTO_REFRESH=0 unless noted; bench shifts on ss_clk rise, captures on ss_en rise)
//  data 0x01234567, dp 0, blank 0 -> captured 0xC0F9A4B0999282F8, 64 ss_clk rises, one frame_done.
//  same, blank_in=0xF0 -> 0xFFFFFFFF999282F8; dp_in=0x01 -> last byte 0x78.
//  raw_mode=1, raw_in=0x0102040810204080 -> captured 0xFEFDFBF7EFDFBF7F.
//  load_valid held during frame with new data -> load_ready=0, second frame sent only after frame_done.
//  rst_n low after 20 ss_clk rises -> ss_clk/ss_dout/ss_en 0 same cycle, no ss_en, next frame clean.
//  CLK_DIV=3, AUTO_REFRESH=1 -> ss_clk period 6 clk, frame 390 clk, frames repeat every 390+48 clk.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and helpers for the serial seven-segment driver.
package sseg_pkg;

  // Width of one segment byte: {dp,g,f,e,d,c,b,a}.
  localparam int SEG_W = 8;

  // Serial transmit states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_GAP
  } state_e;

  // Hex nibble to active-high {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_encoder.sv
// Combinational per-digit segment encoder: hex or raw byte, blanking, output polarity.
module sseg_encoder
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [4*NUM_DIGITS-1:0]     data_i,
  input  logic [NUM_DIGITS-1:0]       dp_i,
  input  logic [NUM_DIGITS-1:0]       blank_i,
  input  logic                        raw_mode_i,
  input  logic [SEG_W*NUM_DIGITS-1:0] raw_i,
  output logic [SEG_W*NUM_DIGITS-1:0] frame_o
);

  localparam logic [SEG_W-1:0] POL_MASK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [SEG_W-1:0] seg_byte;

    // Pick raw or decoded byte for this digit, then apply blanking.
    always_comb begin
      // NOTE: every combinational output gets a value on every path (default first) so no latch is inferred.
      seg_byte = raw_mode_i ? raw_i[d*SEG_W +: SEG_W] : {dp_i[d], hex7(data_i[d*4 +: 4])};
      if (blank_i[d]) begin
        seg_byte = '0;
      end
    end

    assign frame_o[d*SEG_W +: SEG_W] = seg_byte ^ POL_MASK;
  end

endmodule

// File: rtl/sseg_serial_driver.sv
// Serial driver for a daisy chain of 8-bit seven-segment shift registers.
// A frame is captured on accept, shifted MSB first on ss_dout/ss_clk, then latched with ss_en.
module sseg_serial_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AUTO_REFRESH   = 1,
  parameter int GAP_TICKS      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [4*NUM_DIGITS-1:0]     data_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       blank_in,
  input  logic                        raw_mode,
  input  logic [SEG_W*NUM_DIGITS-1:0] raw_in,
  input  logic                        load_valid,
  output logic                        load_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        ss_dout,
  output logic                        ss_clk,
  output logic                        ss_en
);

  localparam int FRAME_W = SEG_W * NUM_DIGITS;
  localparam bit AUTO    = (AUTO_REFRESH != 0);

  // Bit counter holds 0..FRAME_W.
  localparam int               BIT_W      = $clog2(FRAME_W + 1);
  localparam logic [BIT_W-1:0] FRAME_BITS = BIT_W'(FRAME_W);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);

  // Clock divider counts 0..CLK_DIV-1.
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // Phase counter covers the 2-tick latch and the GAP_TICKS gap.
  localparam int              PH_W       = (GAP_TICKS > 2) ? $clog2(GAP_TICKS) : 1;
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_TICKS - 1);
  localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(1);
  localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);

  // All-digits-dark frame after polarity.
  localparam logic [FRAME_W-1:0] DARK_FRAME = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  state_e             state_q,   state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]    phase_q,   phase_d;
  logic [FRAME_W-1:0] frame_q,   frame_d;
  logic [FRAME_W-1:0] shift_q,   shift_d;

  logic load_ready_q, load_ready_d;
  logic busy_q,       busy_d;
  logic frame_done_q, frame_done_d;
  logic ss_dout_q,    ss_dout_d;
  logic ss_clk_q,     ss_clk_d;
  logic ss_en_q,      ss_en_d;

  logic [FRAME_W-1:0] enc_frame;
  logic               tick;
  logic               accept;
  logic               start;

  sseg_encoder #(
    .NUM_DIGITS     (NUM_DIGITS),
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_encoder (
    .data_i     (data_in),
    .dp_i       (dp_in),
    .blank_i    (blank_in),
    .raw_mode_i (raw_mode),
    .raw_i      (raw_in),
    .frame_o    (enc_frame)
  );

  assign tick   = (div_cnt_q == DIV_LAST);
  assign accept = load_valid && load_ready_q;

  // Next-state, counters, frame capture and next registered pin values.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    frame_d   = frame_q;
    shift_d   = shift_q;
    start     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // With auto-refresh the first frame leaves right after reset.
        if (accept || AUTO) begin
          start = 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        if (tick) begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q - BIT_ONE;
          if (bit_cnt_q == BIT_ONE) begin
            state_d = ST_LATCH;
            phase_d = '0;
          end else begin
            state_d = ST_SHIFT_LO;
            shift_d = shift_q << 1;
          end
        end
      end
      ST_LATCH: begin
        if (tick) begin
          if (phase_q == LATCH_LAST) begin
            state_d = AUTO ? ST_GAP : ST_IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_ONE;
          end
        end
      end
      ST_GAP: begin
        // A new load cuts the gap short.
        if (accept) begin
          start = 1'b1;
        end else if (tick) begin
          if (phase_q == GAP_LAST) begin
            start = 1'b1;
          end else begin
            phase_d = phase_q + PH_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start) begin
      state_d   = ST_SHIFT_LO;
      bit_cnt_d = FRAME_BITS;
      phase_d   = '0;
      if (accept) begin
        frame_d = enc_frame;
        shift_d = enc_frame;
      end else begin
        shift_d = frame_q;
      end
    end

    // Divider restarts on every tick and on every state change; parked at 0 in IDLE.
    if (state_d == ST_IDLE || tick || state_d != state_q) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end

    ss_clk_d     = (state_d == ST_SHIFT_HI);
    ss_dout_d    = (state_d == ST_SHIFT_LO || state_d == ST_SHIFT_HI) ? shift_d[FRAME_W-1] : 1'b0;
    ss_en_d      = (state_d == ST_LATCH);
    busy_d       = (state_d == ST_SHIFT_LO || state_d == ST_SHIFT_HI || state_d == ST_LATCH);
    load_ready_d = (state_d == ST_IDLE || state_d == ST_GAP);
    frame_done_d = (state_q == ST_LATCH) && (state_d != ST_LATCH);
  end

  // State, counters, frame/shift registers and registered pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      phase_q      <= '0;
      // NOTE: the held frame is reset to the dark pattern so an auto-refresh straight out of reset blanks the display.
      frame_q      <= DARK_FRAME;
      shift_q      <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ss_dout_q    <= 1'b0;
      ss_clk_q     <= 1'b0;
      ss_en_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      phase_q      <= phase_d;
      frame_q      <= frame_d;
      shift_q      <= shift_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      ss_dout_q    <= ss_dout_d;
      ss_clk_q     <= ss_clk_d;
      ss_en_q      <= ss_en_d;
    end
  end

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign ss_dout    = ss_dout_q;
  assign ss_clk     = ss_clk_q;
  assign ss_en      = ss_en_q;

endmodule

// File: tb/tb_sseg_serial_driver.sv
// Directed self-checking bench for sseg_serial_driver.
// Main DUT: 8 digits, CLK_DIV=1, no auto-refresh. Second DUT: CLK_DIV=3 with auto-refresh.
module tb_sseg_serial_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- main DUT ----------------
  logic        rst_n;
  logic [31:0] data_in;
  logic [7:0]  dp_in, blank_in;
  logic        raw_mode;
  logic [63:0] raw_in;
  logic        load_valid;
  logic        load_ready, busy, frame_done, ss_dout, ss_clk, ss_en;

  sseg_serial_driver #(
    .NUM_DIGITS(8), .CLK_DIV(1), .SEG_ACTIVE_LOW(1), .AUTO_REFRESH(0), .GAP_TICKS(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .raw_mode(raw_mode), .raw_in(raw_in), .load_valid(load_valid), .load_ready(load_ready),
    .busy(busy), .frame_done(frame_done), .ss_dout(ss_dout), .ss_clk(ss_clk), .ss_en(ss_en)
  );

  // ---------------- auto-refresh DUT ----------------
  logic        rst_a_n;
  logic [31:0] a_data;
  logic [7:0]  a_dp, a_blank;
  logic        a_raw_mode;
  logic [63:0] a_raw;
  logic        a_load_valid;
  logic        a_load_ready, a_busy, a_frame_done, a_ss_dout, a_ss_clk, a_ss_en;

  sseg_serial_driver #(
    .NUM_DIGITS(8), .CLK_DIV(3), .SEG_ACTIVE_LOW(1), .AUTO_REFRESH(1), .GAP_TICKS(16)
  ) u_dut_auto (
    .clk(clk), .rst_n(rst_a_n), .data_in(a_data), .dp_in(a_dp), .blank_in(a_blank),
    .raw_mode(a_raw_mode), .raw_in(a_raw), .load_valid(a_load_valid), .load_ready(a_load_ready),
    .busy(a_busy), .frame_done(a_frame_done), .ss_dout(a_ss_dout), .ss_clk(a_ss_clk), .ss_en(a_ss_en)
  );

  // ---------------- receiver models ----------------
  logic [63:0] rx_shreg = '0, rx_frame = '0;
  int          rx_rises = 0, rx_caps = 0, done_cnt = 0, overlap_cnt = 0;
  logic [63:0] a_shreg = '0, a_rx_frame = '0;
  int          a_caps = 0;

  // Chain shift register of the main display.
  always @(posedge ss_clk) begin
    rx_shreg <= {rx_shreg[62:0], ss_dout};
    rx_rises <= rx_rises + 1;
  end

  // Output latch of the main display.
  always @(posedge ss_en) begin
    rx_frame <= rx_shreg;
    rx_caps  <= rx_caps + 1;
  end

  // Chain shift register of the auto-refresh display.
  always @(posedge a_ss_clk) begin
    a_shreg <= {a_shreg[62:0], a_ss_dout};
  end

  // Output latch of the auto-refresh display.
  always @(posedge a_ss_en) begin
    a_rx_frame <= a_shreg;
    a_caps     <= a_caps + 1;
  end

  // frame_done pulses and strobe/clock overlap monitor.
  always @(posedge clk) begin
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    if ((ss_en && ss_clk) || (a_ss_en && a_ss_clk)) overlap_cnt <= overlap_cnt + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input string name, input logic [31:0] d, input logic [7:0] dp,
                             input logic [7:0] bl, input logic rm, input logic [63:0] rw);
    int n;
    @(negedge clk);
    data_in = d; dp_in = dp; blank_in = bl; raw_mode = rm; raw_in = rw; load_valid = 1'b1;
    n = 0;
    while (load_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s_accept_timeout: load_ready got %b want 1", name, load_ready);
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int busy_cyc);
    int n;
    n = 0;
    busy_cyc = 0;
    while (frame_done !== 1'b1 && n < 2000) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: frame_done got %b want 1", name, frame_done);
    end
  endtask

  task automatic run_frame(input string name, input logic [31:0] d, input logic [7:0] dp,
                           input logic [7:0] bl, input logic rm, input logic [63:0] rw,
                           output logic [63:0] cap, output int rises, output int caps,
                           output int dones, output int busy_cyc);
    int r0, c0, d0;
    r0 = rx_rises; c0 = rx_caps; d0 = done_cnt;
    start_frame(name, d, dp, bl, rm, rw);
    wait_done(name, busy_cyc);
    @(negedge clk);
    cap = rx_frame; rises = rx_rises - r0; caps = rx_caps - c0; dones = done_cnt - d0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #12;
    checks++; if (ss_clk !== 1'b0) begin errors++; $display("FAIL reset_ss_clk: got %b want 0", ss_clk); end
    checks++; if (ss_dout !== 1'b0) begin errors++; $display("FAIL reset_ss_dout: got %b want 0", ss_dout); end
    checks++; if (ss_en !== 1'b0) begin errors++; $display("FAIL reset_ss_en: got %b want 0", ss_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0 || rx_rises != 0) begin
      errors++; $display("FAIL idle_no_auto: busy %b rises %0d want 0/0", busy, rx_rises);
    end
  endtask

  task automatic test_basic;
    logic [63:0] cap; int rises, caps, dones, bc;
    run_frame("basic", 32'h01234567, 8'h00, 8'h00, 1'b0, 64'h0, cap, rises, caps, dones, bc);
    checks++; if (cap !== 64'hC0F9A4B0999282F8) begin errors++; $display("FAIL basic_frame: got %h want C0F9A4B0999282F8", cap); end
    checks++; if (rises != 64) begin errors++; $display("FAIL basic_rises: got %0d want 64", rises); end
    checks++; if (caps != 1) begin errors++; $display("FAIL basic_latches: got %0d want 1", caps); end
    checks++; if (dones != 1) begin errors++; $display("FAIL basic_frame_done: got %0d want 1", dones); end
    checks++; if (bc != 130) begin errors++; $display("FAIL basic_frame_time: got %0d want 130", bc); end
  endtask

  task automatic test_blank;
    logic [63:0] cap; int rises, caps, dones, bc;
    run_frame("blank", 32'h01234567, 8'h00, 8'hF0, 1'b0, 64'h0, cap, rises, caps, dones, bc);
    checks++; if (cap !== 64'hFFFFFFFF999282F8) begin errors++; $display("FAIL blank_frame: got %h want FFFFFFFF999282F8", cap); end
  endtask

  task automatic test_dp;
    logic [63:0] cap; int rises, caps, dones, bc;
    run_frame("dp", 32'h01234567, 8'h01, 8'h00, 1'b0, 64'h0, cap, rises, caps, dones, bc);
    checks++; if (cap[7:0] !== 8'h78) begin errors++; $display("FAIL dp_byte0: got %h want 78", cap[7:0]); end
    checks++; if (cap !== 64'hC0F9A4B099928278) begin errors++; $display("FAIL dp_frame: got %h want C0F9A4B099928278", cap); end
  endtask

  task automatic test_raw;
    logic [63:0] cap; int rises, caps, dones, bc;
    run_frame("raw", 32'hFFFFFFFF, 8'hFF, 8'h00, 1'b1, 64'h0102040810204080, cap, rises, caps, dones, bc);
    checks++; if (cap !== 64'hFEFDFBF7EFDFBF7F) begin errors++; $display("FAIL raw_frame: got %h want FEFDFBF7EFDFBF7F", cap); end
    checks++; if (rises != 64) begin errors++; $display("FAIL raw_rises: got %0d want 64", rises); end
  endtask

  task automatic test_back_to_back;
    int r0, c0, d0, n, bc;
    r0 = rx_rises; c0 = rx_caps; d0 = done_cnt;
    @(negedge clk);
    data_in = 32'h89ABCDEF; dp_in = 8'h00; blank_in = 8'h00; raw_mode = 1'b0; raw_in = '0; load_valid = 1'b1;
    n = 0;
    while (load_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    // Accepted; change data and keep requesting.
    data_in = 32'h01234567;
    repeat (10) @(negedge clk);
    checks++; if (load_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_mid: ready %b busy %b want 0/1", load_ready, busy);
    end
    wait_done("b2b_first", bc);
    checks++; if (rx_frame !== 64'h80908883C6A1868E) begin errors++; $display("FAIL b2b_first_frame: got %h want 80908883C6A1868E", rx_frame); end
    checks++; if (rx_rises - r0 != 64) begin errors++; $display("FAIL b2b_first_rises: got %0d want 64", rx_rises - r0); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_start: busy got %b want 1", busy); end
    load_valid = 1'b0;
    wait_done("b2b_second", bc);
    @(negedge clk);
    checks++; if (rx_frame !== 64'hC0F9A4B0999282F8) begin errors++; $display("FAIL b2b_second_frame: got %h want C0F9A4B0999282F8", rx_frame); end
    checks++; if (rx_rises - r0 != 128) begin errors++; $display("FAIL b2b_total_rises: got %0d want 128", rx_rises - r0); end
    repeat (200) @(negedge clk);
    checks++; if (done_cnt - d0 != 2 || rx_caps - c0 != 2) begin
      errors++; $display("FAIL b2b_no_queue: done %0d latches %0d want 2/2", done_cnt - d0, rx_caps - c0);
    end
  endtask

  task automatic test_reset_mid;
    int r0, c0, n;
    logic [63:0] cap; int rises, caps, dones, bc;
    r0 = rx_rises; c0 = rx_caps;
    start_frame("rst_mid", 32'h89ABCDEF, 8'h00, 8'h00, 1'b0, 64'h0);
    n = 0;
    while (rx_rises - r0 < 20 && n < 500) begin @(negedge clk); n++; end
    checks++; if (rx_rises - r0 < 20) begin errors++; $display("FAIL rst_mid_wait: rises %0d want 20", rx_rises - r0); end
    rst_n = 1'b0;
    #1;
    checks++; if (ss_clk !== 1'b0 || ss_dout !== 1'b0 || ss_en !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pins: clk %b dout %b en %b want 0/0/0", ss_clk, ss_dout, ss_en);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_caps != c0) begin errors++; $display("FAIL rst_mid_no_latch: latches %0d want %0d", rx_caps, c0); end
    run_frame("rst_after", 32'h01234567, 8'h00, 8'h00, 1'b0, 64'h0, cap, rises, caps, dones, bc);
    checks++; if (cap !== 64'hC0F9A4B0999282F8 || rises != 64) begin
      errors++; $display("FAIL rst_after_frame: got %h rises %0d want C0F9A4B0999282F8/64", cap, rises);
    end
  endtask

  task automatic test_refresh;
    int clk_r0, clk_r1, busy_r, busy_f, en_r0, en_r1, n;
    logic p_clk, p_busy, p_en;
    clk_r0 = -1; clk_r1 = -1; busy_r = -1; busy_f = -1; en_r0 = -1; en_r1 = -1;
    p_clk = 1'b0; p_busy = 1'b0; p_en = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (a_ss_clk && !p_clk) begin
        if (clk_r0 < 0) clk_r0 = k; else if (clk_r1 < 0) clk_r1 = k;
      end
      if (a_busy && !p_busy && busy_r < 0) busy_r = k;
      if (!a_busy && p_busy && busy_f < 0) busy_f = k;
      if (a_ss_en && !p_en) begin
        if (en_r0 < 0) en_r0 = k; else if (en_r1 < 0) en_r1 = k;
      end
      p_clk = a_ss_clk; p_busy = a_busy; p_en = a_ss_en;
    end
    checks++; if (clk_r1 - clk_r0 != 6) begin errors++; $display("FAIL auto_sclk_period: got %0d want 6", clk_r1 - clk_r0); end
    checks++; if (busy_f - busy_r != 390) begin errors++; $display("FAIL auto_frame_time: got %0d want 390", busy_f - busy_r); end
    checks++; if (en_r1 - en_r0 != 438) begin errors++; $display("FAIL auto_refresh_period: got %0d want 438", en_r1 - en_r0); end
    checks++; if (a_rx_frame !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL auto_dark_frame: got %h want FFFFFFFFFFFFFFFF", a_rx_frame); end
    // Load during the gap: gap aborted, new frame starts at once.
    n = 0;
    while (a_frame_done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++; if (a_load_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL gap_state: ready %b busy %b want 1/0", a_load_ready, a_busy);
    end
    a_data = 32'h01234567; a_load_valid = 1'b1;
    @(negedge clk);
    a_load_valid = 1'b0;
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL gap_abort_start: busy got %b want 1", a_busy); end
    n = 0;
    while (a_frame_done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (a_rx_frame !== 64'hC0F9A4B0999282F8) begin errors++; $display("FAIL gap_load_frame: got %h want C0F9A4B0999282F8", a_rx_frame); end
  endtask

  initial begin
    rst_n = 1'b0; rst_a_n = 1'b0;
    data_in = '0; dp_in = '0; blank_in = '0; raw_mode = 1'b0; raw_in = '0; load_valid = 1'b0;
    a_data = '0; a_dp = '0; a_blank = '0; a_raw_mode = 1'b0; a_raw = '0; a_load_valid = 1'b0;
    test_reset;
    test_basic;
    test_blank;
    test_dp;
    test_raw;
    test_back_to_back;
    test_reset_mid;
    test_refresh;
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL en_clk_overlap: got %0d want 0", overlap_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
